// File: rtl/nclic_nest_ctrl.sv
// Nested interrupt controller: per-line config/vector CSR tables, edge/level sampling,
// priority arbitration against a hardware preemption stack, registered offer to the core.
package nclic_pkg;
    typedef enum logic [2:0] {
        CSR_NONE = 3'b000,
        CSR_RW   = 3'b001,
        CSR_RS   = 3'b010,
        CSR_RC   = 3'b011,
        CSR_RWI  = 3'b101,
        CSR_RSI  = 3'b110,
        CSR_RCI  = 3'b111
    } csr_op_t;
endpackage

module nclic_nest_ctrl
    import nclic_pkg::*;
#(
    parameter int          NoInterrupts = 8,
    parameter int          PrioBits     = 3,
    parameter int          StackDepth   = 4,
    parameter logic [11:0] CfgAddrBot   = 12'hB00,
    localparam int         IW           = $clog2(NoInterrupts),
    localparam int         DW           = $clog2(StackDepth + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    csr_enable,
    input  logic [11:0]             i_csr_addr,
    input  csr_op_t                 csr_op,
    input  logic [4:0]              rs1_zimm,
    input  logic [31:0]             rs1_data,
    output logic [31:0]             o_csr_rdata,
    input  logic [NoInterrupts-1:0] i_irq,
    input  logic                    i_global_ie,
    input  logic                    i_int_ack,
    input  logic                    i_mret,
    output logic                    o_int,
    output logic [IW-1:0]           o_idx,
    output logic [PrioBits-1:0]     o_prio,
    output logic [31:0]             o_vector,
    output logic [PrioBits-1:0]     o_level,
    output logic [DW-1:0]           o_depth
);

    logic [11:0]             csr_off;
    logic                    csr_write;
    logic [31:0]             csr_operand;
    logic [31:0]             csr_new;
    logic                    lvl_hit;
    logic [NoInterrupts-1:0] cfg_hit;
    logic [NoInterrupts-1:0] vec_hit;
    logic [NoInterrupts-1:0] cand;
    logic [PrioBits-1:0]     prio_arr [NoInterrupts];
    logic [31:0]             cfg_word [NoInterrupts];
    logic [31:0]             vec_arr  [NoInterrupts];

    logic [IW-1:0]           stk_idx_reg  [StackDepth];
    logic [PrioBits-1:0]     stk_prio_reg [StackDepth];
    logic [DW-1:0]           depth_reg;
    logic [DW-1:0]           push_slot;
    logic [PrioBits-1:0]     level_w;
    logic [IW-1:0]           top_idx;
    logic                    running;
    logic                    room;
    logic                    take;
    logic                    pop;
    logic                    push;

    logic                    found;
    logic [IW-1:0]           best_idx;
    logic [PrioBits-1:0]     best_prio;
    logic [31:0]             best_vec;

    // CSR decode; the update is computed once from the old value of whichever CSR is addressed
    always_comb begin
        csr_off     = i_csr_addr - CfgAddrBot;
        lvl_hit     = (csr_off == 12'(2 * NoInterrupts));
        csr_write   = csr_enable && (csr_op[1:0] != 2'b00);
        csr_operand = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;
        case (csr_op[1:0])
            2'b01:   csr_new = csr_operand;
            2'b10:   csr_new = o_csr_rdata | csr_operand;
            2'b11:   csr_new = o_csr_rdata & ~csr_operand;
            default: csr_new = o_csr_rdata;
        endcase
    end

    always_comb begin
        o_csr_rdata = '0;
        for (int i = 0; i < NoInterrupts; i++) begin
            if (cfg_hit[i]) o_csr_rdata = o_csr_rdata | cfg_word[i];
            if (vec_hit[i]) o_csr_rdata = o_csr_rdata | vec_arr[i];
        end
        if (lvl_hit) o_csr_rdata = {{(32 - PrioBits){1'b0}}, level_w};
    end

    for (genvar gi = 0; gi < NoInterrupts; gi++) begin : g_irq
        logic                pend_reg;
        logic                pend_next;
        logic                en_reg;
        logic                edge_mode_reg;
        logic                prev_reg;
        logic                hw_set;
        logic [PrioBits-1:0] prio_reg;
        logic [31:0]         vec_reg;

        assign cfg_hit[gi] = (csr_off == 12'(gi));
        assign vec_hit[gi] = (csr_off == 12'(NoInterrupts + gi));
        assign hw_set      = edge_mode_reg ? (i_irq[gi] & ~prev_reg) : i_irq[gi];

        // Later assignments win: ack clear < CSR write < hardware set
        always_comb begin
            pend_next = pend_reg;
            if (take && (o_idx == IW'(gi))) pend_next = 1'b0;
            if (csr_write && cfg_hit[gi])   pend_next = csr_new[0];
            if (hw_set)                     pend_next = 1'b1;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                pend_reg      <= 1'b0;
                en_reg        <= 1'b0;
                edge_mode_reg <= 1'b0;
                prev_reg      <= 1'b0;
                prio_reg      <= '0;
                vec_reg       <= '0;
            end else begin
                pend_reg <= pend_next;
                prev_reg <= i_irq[gi];
                if (csr_write && cfg_hit[gi]) begin
                    en_reg        <= csr_new[1];
                    edge_mode_reg <= csr_new[2];
                    prio_reg      <= csr_new[3 +: PrioBits];
                end
                if (csr_write && vec_hit[gi]) vec_reg <= csr_new;
            end
        end

        assign prio_arr[gi] = prio_reg;
        assign vec_arr[gi]  = vec_reg;
        assign cfg_word[gi] = {{(29 - PrioBits){1'b0}}, prio_reg, edge_mode_reg, en_reg, pend_reg};
        // The handler currently on top of the stack is never re-offered to itself
        assign cand[gi]     = pend_reg & en_reg & (prio_reg > level_w) & i_global_ie & room
                              & ~(running && (top_idx == IW'(gi)));
    end

    always_comb begin
        level_w = '0;
        top_idx = '0;
        for (int i = 0; i < StackDepth; i++) begin
            if (DW'(i + 1) == depth_reg) begin
                level_w = stk_prio_reg[i];
                top_idx = stk_idx_reg[i];
            end
        end
        running   = (depth_reg != '0);
        room      = (depth_reg < DW'(StackDepth));
        take      = i_int_ack && o_int;
        pop       = i_mret && running;
        push      = take && (pop || room);
        push_slot = pop ? depth_reg - DW'(1) : depth_reg;
    end

    // Highest priority wins; strict compare keeps the lowest index on ties
    always_comb begin
        found     = 1'b0;
        best_idx  = '0;
        best_prio = '0;
        best_vec  = '0;
        for (int i = 0; i < NoInterrupts; i++) begin
            if (cand[i] && (!found || (prio_arr[i] > best_prio))) begin
                found     = 1'b1;
                best_idx  = IW'(i);
                best_prio = prio_arr[i];
                best_vec  = vec_arr[i];
            end
        end
    end

    // Pop-then-push on the same edge overwrites the top entry (tail-chain)
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_reg <= '0;
            for (int i = 0; i < StackDepth; i++) begin
                stk_idx_reg[i]  <= '0;
                stk_prio_reg[i] <= '0;
            end
        end else begin
            if (push) begin
                for (int i = 0; i < StackDepth; i++) begin
                    if (DW'(i) == push_slot) begin
                        stk_idx_reg[i]  <= o_idx;
                        stk_prio_reg[i] <= o_prio;
                    end
                end
            end
            if (push && !pop) begin
                depth_reg <= depth_reg + DW'(1);
            end else if (pop && !push) begin
                depth_reg <= depth_reg - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_int    <= 1'b0;
            o_idx    <= '0;
            o_prio   <= '0;
            o_vector <= '0;
        end else if (take) begin
            o_int <= 1'b0;
        end else begin
            o_int    <= found;
            o_idx    <= best_idx;
            o_prio   <= best_prio;
            o_vector <= best_vec;
        end
    end

    assign o_level = level_w;
    assign o_depth = depth_reg;

endmodule

// File: tb/tb_nclic_nest_ctrl.sv
// Directed bench for nclic_nest_ctrl: each task drives one scenario and checks inline.
module tb_nclic_nest_ctrl;
    import nclic_pkg::*;

    localparam logic [11:0] CFG = 12'hB00;
    localparam logic [11:0] VEC = 12'hB08;
    localparam logic [11:0] LVL = 12'hB10;

    logic        clk;
    logic        reset;
    logic        csr_enable;
    logic [11:0] i_csr_addr;
    csr_op_t     csr_op;
    logic [4:0]  rs1_zimm;
    logic [31:0] rs1_data;
    logic [31:0] o_csr_rdata;
    logic [7:0]  i_irq;
    logic        i_global_ie;
    logic        i_int_ack;
    logic        i_mret;
    logic        o_int;
    logic [2:0]  o_idx;
    logic [2:0]  o_prio;
    logic [31:0] o_vector;
    logic [2:0]  o_level;
    logic [2:0]  o_depth;

    int tests_run;
    int tests_failed;
    logic [31:0] rd;

    nclic_nest_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .csr_enable  (csr_enable),
        .i_csr_addr  (i_csr_addr),
        .csr_op      (csr_op),
        .rs1_zimm    (rs1_zimm),
        .rs1_data    (rs1_data),
        .o_csr_rdata (o_csr_rdata),
        .i_irq       (i_irq),
        .i_global_ie (i_global_ie),
        .i_int_ack   (i_int_ack),
        .i_mret      (i_mret),
        .o_int       (o_int),
        .o_idx       (o_idx),
        .o_prio      (o_prio),
        .o_vector    (o_vector),
        .o_level     (o_level),
        .o_depth     (o_depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic csr_wr(input logic [11:0] a, input csr_op_t op, input logic [31:0] d);
        csr_enable = 1'b1;
        i_csr_addr = a;
        csr_op     = op;
        rs1_data   = d;
        rs1_zimm   = d[4:0];
        tick();
        csr_enable = 1'b0;
        csr_op     = CSR_NONE;
        rs1_data   = '0;
        rs1_zimm   = '0;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        i_csr_addr = a;
        #1;
        d = o_csr_rdata;
    endtask

    task automatic pulse(input int line);
        i_irq[line] = 1'b1;
        tick();
        i_irq[line] = 1'b0;
    endtask

    task automatic ack();
        i_int_ack = 1'b1;
        tick();
        i_int_ack = 1'b0;
    endtask

    task automatic mret();
        i_mret = 1'b1;
        tick();
        i_mret = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (o_int !== 1'b0) begin tests_failed++; $display("FAIL reset_o_int: got %0d expected 0", o_int); end
        tests_run++; if (o_idx !== 3'd0) begin tests_failed++; $display("FAIL reset_o_idx: got %0d expected 0", o_idx); end
        tests_run++; if (o_vector !== 32'h0) begin tests_failed++; $display("FAIL reset_o_vector: got %h expected 0", o_vector); end
        tests_run++; if (o_level !== 3'd0) begin tests_failed++; $display("FAIL reset_o_level: got %0d expected 0", o_level); end
        tests_run++; if (o_depth !== 3'd0) begin tests_failed++; $display("FAIL reset_o_depth: got %0d expected 0", o_depth); end
        csr_rd(CFG + 12'd3, rd);
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_cfg3: got %h expected 0", rd); end
        $display("[TB] reset done");
    endtask

    task automatic test_basic();
        do_reset();
        csr_wr(CFG + 12'd0, CSR_RW, 32'h16);
        csr_wr(VEC + 12'd0, CSR_RW, 32'h100);
        pulse(0);
        tests_run++; if (o_int !== 1'b0) begin tests_failed++; $display("FAIL basic_latency_early: got %0d expected 0", o_int); end
        csr_rd(CFG + 12'd0, rd);
        tests_run++; if (rd !== 32'h17) begin tests_failed++; $display("FAIL basic_pending_set: got %h expected 17", rd); end
        tick();
        tests_run++; if (o_int !== 1'b1) begin tests_failed++; $display("FAIL basic_o_int: got %0d expected 1", o_int); end
        tests_run++; if (o_idx !== 3'd0) begin tests_failed++; $display("FAIL basic_o_idx: got %0d expected 0", o_idx); end
        tests_run++; if (o_prio !== 3'd2) begin tests_failed++; $display("FAIL basic_o_prio: got %0d expected 2", o_prio); end
        tests_run++; if (o_vector !== 32'h100) begin tests_failed++; $display("FAIL basic_o_vector: got %h expected 100", o_vector); end
        ack();
        tests_run++; if (o_int !== 1'b0) begin tests_failed++; $display("FAIL basic_ack_o_int: got %0d expected 0", o_int); end
        tests_run++; if (o_level !== 3'd2) begin tests_failed++; $display("FAIL basic_ack_level: got %0d expected 2", o_level); end
        tests_run++; if (o_depth !== 3'd1) begin tests_failed++; $display("FAIL basic_ack_depth: got %0d expected 1", o_depth); end
        csr_rd(CFG + 12'd0, rd);
        tests_run++; if (rd !== 32'h16) begin tests_failed++; $display("FAIL basic_pending_cleared: got %h expected 16", rd); end
        csr_wr(LVL, CSR_RW, 32'h5);
        tests_run++; if (o_level !== 3'd2) begin tests_failed++; $display("FAIL basic_level_write: got %0d expected 2", o_level); end
        csr_rd(LVL, rd);
        tests_run++; if (rd !== 32'h2) begin tests_failed++; $display("FAIL basic_level_read: got %h expected 2", rd); end
        $display("[TB] basic offer/take done");
    endtask

    task automatic test_preempt();
        csr_wr(CFG + 12'd3, CSR_RW, 32'h2E);
        pulse(3);
        tick();
        tests_run++; if (o_int !== 1'b1 || o_idx !== 3'd3) begin tests_failed++; $display("FAIL preempt_offer: got int=%0d idx=%0d expected int=1 idx=3", o_int, o_idx); end
        ack();
        tests_run++; if (o_depth !== 3'd2 || o_level !== 3'd5) begin tests_failed++; $display("FAIL preempt_push: got depth=%0d level=%0d expected depth=2 level=5", o_depth, o_level); end
        mret();
        tests_run++; if (o_depth !== 3'd1 || o_level !== 3'd2) begin tests_failed++; $display("FAIL preempt_mret1: got depth=%0d level=%0d expected depth=1 level=2", o_depth, o_level); end
        mret();
        tests_run++; if (o_depth !== 3'd0 || o_level !== 3'd0) begin tests_failed++; $display("FAIL preempt_mret2: got depth=%0d level=%0d expected depth=0 level=0", o_depth, o_level); end
        mret();
        tests_run++; if (o_depth !== 3'd0) begin tests_failed++; $display("FAIL preempt_empty_mret: got depth=%0d expected 0", o_depth); end
        $display("[TB] preemption done");
    endtask

    task automatic test_tie_threshold();
        do_reset();
        csr_wr(CFG + 12'd1, CSR_RW, 32'h1E);
        csr_wr(CFG + 12'd4, CSR_RW, 32'h1E);
        i_irq[1] = 1'b1;
        i_irq[4] = 1'b1;
        tick();
        i_irq = '0;
        tick();
        tests_run++; if (o_int !== 1'b1 || o_idx !== 3'd1) begin tests_failed++; $display("FAIL tie_idx: got int=%0d idx=%0d expected int=1 idx=1", o_int, o_idx); end
        ack();
        tick();
        tick();
        tests_run++; if (o_int !== 1'b0) begin tests_failed++; $display("FAIL threshold_equal: got %0d expected 0", o_int); end
        csr_rd(CFG + 12'd4, rd);
        tests_run++; if (rd !== 32'h1F) begin tests_failed++; $display("FAIL threshold_pending4: got %h expected 1f", rd); end
        mret();
        tests_run++; if (o_int !== 1'b0) begin tests_failed++; $display("FAIL mret_latency_early: got %0d expected 0", o_int); end
        tick();
        tests_run++; if (o_int !== 1'b1 || o_idx !== 3'd4) begin tests_failed++; $display("FAIL mret_reoffer: got int=%0d idx=%0d expected int=1 idx=4", o_int, o_idx); end
        $display("[TB] tie/threshold done");
    endtask

    task automatic test_tail_chain();
        do_reset();
        csr_wr(CFG + 12'd1, CSR_RW, 32'h1E);
        csr_wr(CFG + 12'd3, CSR_RW, 32'h2E);
        pulse(1);
        tick();
        ack();
        pulse(3);
        tick();
        tests_run++; if (o_int !== 1'b1 || o_idx !== 3'd3) begin tests_failed++; $display("FAIL chain_offer: got int=%0d idx=%0d expected int=1 idx=3", o_int, o_idx); end
        i_int_ack = 1'b1;
        i_mret    = 1'b1;
        tick();
        i_int_ack = 1'b0;
        i_mret    = 1'b0;
        tests_run++; if (o_depth !== 3'd1 || o_level !== 3'd5) begin tests_failed++; $display("FAIL chain_top: got depth=%0d level=%0d expected depth=1 level=5", o_depth, o_level); end
        tests_run++; if (o_int !== 1'b0) begin tests_failed++; $display("FAIL chain_o_int: got %0d expected 0", o_int); end
        mret();
        tests_run++; if (o_depth !== 3'd0 || o_level !== 3'd0) begin tests_failed++; $display("FAIL chain_pop: got depth=%0d level=%0d expected 0/0", o_depth, o_level); end
        $display("[TB] tail-chain done");
    endtask

    task automatic test_full_stack();
        do_reset();
        for (int l = 0; l < 4; l++) begin
            csr_wr(CFG + 12'(l), CSR_RW, 32'h6 | (32'(l + 1) << 3));
            pulse(l);
            tick();
            tests_run++; if (o_int !== 1'b1 || o_idx !== 3'(l)) begin tests_failed++; $display("FAIL full_fill_%0d: got int=%0d idx=%0d expected int=1 idx=%0d", l, o_int, o_idx, l); end
            ack();
        end
        tests_run++; if (o_depth !== 3'd4 || o_level !== 3'd4) begin tests_failed++; $display("FAIL full_depth: got depth=%0d level=%0d expected 4/4", o_depth, o_level); end
        csr_wr(CFG + 12'd7, CSR_RW, 32'h3E);
        pulse(7);
        tick();
        tick();
        tests_run++; if (o_int !== 1'b0) begin tests_failed++; $display("FAIL full_no_offer: got %0d expected 0", o_int); end
        csr_rd(CFG + 12'd7, rd);
        tests_run++; if (rd !== 32'h3F) begin tests_failed++; $display("FAIL full_pending_kept: got %h expected 3f", rd); end
        mret();
        tests_run++; if (o_depth !== 3'd3 || o_int !== 1'b0) begin tests_failed++; $display("FAIL full_pop: got depth=%0d int=%0d expected depth=3 int=0", o_depth, o_int); end
        tick();
        tests_run++; if (o_int !== 1'b1 || o_idx !== 3'd7 || o_prio !== 3'd7) begin tests_failed++; $display("FAIL full_reoffer: got int=%0d idx=%0d prio=%0d expected 1/7/7", o_int, o_idx, o_prio); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++; if (o_depth !== 3'd0 || o_level !== 3'd0 || o_int !== 1'b0) begin tests_failed++; $display("FAIL midreset: got depth=%0d level=%0d int=%0d expected 0/0/0", o_depth, o_level, o_int); end
        csr_rd(CFG + 12'd7, rd);
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL midreset_cfg7: got %h expected 0", rd); end
        $display("[TB] full stack / mid-handler reset done");
    endtask

    task automatic test_level_mode();
        do_reset();
        csr_wr(CFG + 12'd2, CSR_RW, 32'h12);
        i_irq[2] = 1'b1;
        tick();
        tick();
        tests_run++; if (o_int !== 1'b1 || o_idx !== 3'd2) begin tests_failed++; $display("FAIL level_offer: got int=%0d idx=%0d expected 1/2", o_int, o_idx); end
        ack();
        csr_rd(CFG + 12'd2, rd);
        tests_run++; if (rd !== 32'h13) begin tests_failed++; $display("FAIL level_repend: got %h expected 13", rd); end
        tick();
        tests_run++; if (o_int !== 1'b0 || o_level !== 3'd2) begin tests_failed++; $display("FAIL level_held: got int=%0d level=%0d expected 0/2", o_int, o_level); end
        mret();
        tests_run++; if (o_level !== 3'd0 || o_int !== 1'b0) begin tests_failed++; $display("FAIL level_mret: got level=%0d int=%0d expected 0/0", o_level, o_int); end
        tick();
        tests_run++; if (o_int !== 1'b1 || o_idx !== 3'd2) begin tests_failed++; $display("FAIL level_reoffer: got int=%0d idx=%0d expected 1/2", o_int, o_idx); end
        i_irq[2] = 1'b0;
        $display("[TB] level mode done");
    endtask

    task automatic test_csr_precedence();
        do_reset();
        csr_wr(CFG + 12'd0, CSR_RW, 32'h16);
        i_irq[0] = 1'b1;
        csr_wr(CFG + 12'd0, CSR_RC, 32'h1);
        i_irq[0] = 1'b0;
        csr_rd(CFG + 12'd0, rd);
        tests_run++; if (rd !== 32'h17) begin tests_failed++; $display("FAIL prec_edge_over_clear: got %h expected 17", rd); end
        csr_wr(CFG + 12'd0, CSR_RW, 32'h0);
        tick();
        csr_wr(CFG + 12'd5, CSR_RW, 32'h1B);
        tests_run++; if (o_int !== 1'b0) begin tests_failed++; $display("FAIL csrset_early: got %0d expected 0", o_int); end
        tick();
        tests_run++; if (o_int !== 1'b1 || o_idx !== 3'd5 || o_prio !== 3'd3) begin tests_failed++; $display("FAIL csrset_offer: got int=%0d idx=%0d prio=%0d expected 1/5/3", o_int, o_idx, o_prio); end
        csr_wr(CFG + 12'd5, CSR_RC, 32'h2);
        tick();
        tests_run++; if (o_int !== 1'b0) begin tests_failed++; $display("FAIL disable_drop: got %0d expected 0", o_int); end
        csr_wr(VEC + 12'd1, CSR_RW, 32'hF0);
        csr_wr(VEC + 12'd1, CSR_RS, 32'h0F);
        csr_rd(VEC + 12'd1, rd);
        tests_run++; if (rd !== 32'hFF) begin tests_failed++; $display("FAIL vec_set: got %h expected ff", rd); end
        csr_wr(VEC + 12'd1, CSR_RC, 32'hF0);
        csr_rd(VEC + 12'd1, rd);
        tests_run++; if (rd !== 32'h0F) begin tests_failed++; $display("FAIL vec_clear: got %h expected 0f", rd); end
        csr_wr(CFG + 12'd6, CSR_RW, 32'hFFFF_FFFF);
        csr_rd(CFG + 12'd6, rd);
        tests_run++; if (rd !== 32'h3F) begin tests_failed++; $display("FAIL cfg_mask: got %h expected 3f", rd); end
        csr_wr(CFG + 12'd1, CSR_RWI, 32'h1E);
        csr_rd(CFG + 12'd1, rd);
        tests_run++; if (rd !== 32'h1E) begin tests_failed++; $display("FAIL cfg_imm: got %h expected 1e", rd); end
        csr_rd(12'hB11, rd);
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL unmapped_b11: got %h expected 0", rd); end
        csr_rd(12'h300, rd);
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL unmapped_300: got %h expected 0", rd); end
        $display("[TB] csr precedence done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        csr_enable   = 1'b0;
        i_csr_addr   = '0;
        csr_op       = CSR_NONE;
        rs1_zimm     = '0;
        rs1_data     = '0;
        i_irq        = '0;
        i_global_ie  = 1'b1;
        i_int_ack    = 1'b0;
        i_mret       = 1'b0;
        test_reset();
        test_basic();
        test_preempt();
        test_tie_threshold();
        test_tail_chain();
        test_full_stack();
        test_level_mode();
        test_csr_precedence();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nclic_nest_ctrl.md
# nclic_nest_ctrl

Parametrised nested-interrupt controller: it is the next generation of the NCLIC top level. It holds per-interrupt config and vector CSR tables behind the core's CSR port and samples external sources in edge or level mode. It arbitrates against a running priority level kept on a hardware preemption stack, and drives a registered take request plus a trap vector to the core's trap logic. Priority width, nesting depth and interrupt count are parameters; mret pop and tail-chaining are handled in-block.

## Interface
- NoInterrupts, 8: number of interrupt lines, 2..64.
- PrioBits, 3: priority width; level 0 is the base (thread) level.
- StackDepth, 4: maximum nesting depth, 1..16.
- CfgAddrBot, 12'hB00: CSR address of config word 0.
- clk  in  1  clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- csr_enable  in  1  a CSR instruction is executing this cycle.
- i_csr_addr  in  12  CSR address (CsrAddrT).
- csr_op  in  csr_op_t  write/set/clear, register or immediate form.
- rs1_zimm  in  5  immediate operand, zero-extended, used for immediate forms.
- rs1_data  in  32  register operand.
- o_csr_rdata  out  32  old value of the addressed CSR, combinational; 0 when the address is unmapped.
- i_irq  in  NoInterrupts  external sources, synchronous to clk.
- i_global_ie  in  1  global interrupt enable.
- i_int_ack  in  1  core takes the offered interrupt.
- i_mret  in  1  core returns from the current handler.
- o_int  out  1  interrupt offered, registered.
- o_idx  out  $clog2(NoInterrupts)  index of the offered interrupt.
- o_prio  out  PrioBits  priority of the offered interrupt.
- o_vector  out  32  handler address of the offered interrupt.
- o_level  out  PrioBits  current running level (top-of-stack priority, 0 when empty).
- o_depth  out  $clog2(StackDepth+1)  stack occupancy.

## Operation
- CSR map:
  - CfgAddrBot+i is config i: bit0 pending, bit1 enabled, bit2 edge (1 = edge, 0 = level), bits[3+:PrioBits] prio, other bits read 0.
  - CfgAddrBot+NoInterrupts+i is vector i, full 32 bits read/write.
  - CfgAddrBot+2·NoInterrupts is LEVEL, read-only; writes are ignored.
- CSR update: write replaces the value, set ORs the operand in, clear ANDs in the operand's complement.
- Pending precedence, lowest to highest:
  - ack clear;
  - CSR write;
  - hardware set, which is a rising edge of i_irq in edge mode, or i_irq high in level mode.
  - A level source still high after its ack therefore re-pends on the same edge.
- Candidate: pending & enabled & prio > o_level, with i_global_ie=1 and o_depth < StackDepth.
- Winner: highest prio; ties go to the lowest index.
- Stack entries hold {idx, prio}.
  - Ack with o_int=1 clears pending[o_idx] and pushes {o_idx, o_prio}.
  - mret pops; mret on an empty stack is ignored.
- Ack and mret in the same cycle: pop then push, so the top entry is replaced and depth is unchanged (tail-chain).
- Ack while o_int=0 is ignored.
- Full stack: no candidate is offered; pending interrupts stay pending.

## Timing
- Reset: all config and vector entries 0, edge-detect history 0, stack empty. o_int, o_idx, o_prio, o_vector, o_level and o_depth are all 0.
- i_irq sampling:
  - i_irq is sampled at edge k and pending is visible after k.
  - o_int/o_idx/o_prio/o_vector register the arbitration result at edge k+1, giving a 2-cycle irq-to-o_int latency.
  - A CSR-set pending at edge k gives o_int after k+1.
- Take:
  - On the edge that samples i_int_ack, o_int is forced to 0 and the push occurs.
  - o_level updates at that same edge.
  - Arbitration resumes and the next o_int may appear one edge later.
- mret: the pop happens at edge k and o_level drops after k. A waiting candidate above the new level is offered after k+1.
- Offer refresh: while o_int=1 without ack, outputs re-evaluate every edge, so a higher-priority arrival replaces the offer. o_int drops if the candidate vanishes, through disable, clear or a level change.
- Reset mid-handler: the stack is emptied and tables are cleared at that edge, with no pop or ack side effects.

## Test plan
- Reset, then program cfg0 = enabled|edge|prio 2 and vector0 = 0x100, and pulse i_irq[0] at edge 10. Expect o_int=1, o_idx=0, o_vector=0x100 after edge 11; after ack, pending0=0, o_level=2, o_depth=1.
- Preemption: irq3 is at prio 5 while level=2, then ack; expect depth 2, level 5. mret gives level 2; a second mret gives level 0, depth 0.
- Tie and threshold:
  - irq1 and irq4 both at prio 3 pending simultaneously; expect o_idx=1.
  - At level 3, a prio-3 source is not offered.
- Tail-chain and full stack:
  - Ack and mret in the same cycle; expect depth unchanged and top = new idx/prio.
  - With StackDepth=1 and depth 1, a prio-7 pending source gives o_int=0.
- Level mode: hold irq2 high through ack; expect pending2=1 again after the ack edge and re-offer once level drops on mret.
- CSR precedence:
  - A clear of pending in the same cycle as an edge on that line leaves pending=1.
  - Writes to LEVEL leave o_level unchanged.
  - An unmapped read gives 0.
